// File: rtl/mem_access_if.sv
// mem_access_if: word-wide req/ack memory bus between mem_access (master) and memory (slave).
// Rev 1.0
`default_nettype none

interface mem_access_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

`default_nettype wire

// File: rtl/mem_access.sv
// mem_access: multicycle-controller memory access unit (req/ack bus, byte lanes, load extension).
// Rev 1.0
`default_nettype none

module mem_access #(
    parameter int TIMEOUT = 16
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        start,
    input  wire logic [1:0]  IorD,
    input  wire logic        MemWrite,
    input  wire logic        IRWrite,
    input  wire logic [5:0]  op,
    input  wire logic [31:0] pc,
    input  wire logic [31:0] alu_out,
    input  wire logic [31:0] rt_data,
    mem_access_if.master     mbus,
    output logic [31:0]      ir,
    output logic [31:0]      mdr,
    output logic             busy,
    output logic             done,
    output logic             misalign,
    output logic             bus_err
);
    localparam int         CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;
    state_t state_q, state_d;

    logic [CW-1:0] cnt;
    logic [1:0]    size_q, a_q;
    logic          sext_q, fetch_q, store_q, irwrite_q;

    logic          fetch, store, sext, mis, timeout_hit;
    logic [1:0]    size, a;
    logic [31:0]   sel_addr, wdata, rd_shift, load_val;
    logic [15:0]   rd_half;
    logic [3:0]    be;

    // Access decode from the live inputs; only used on the IDLE start edge.
    always_comb begin
        fetch    = (IorD == 2'b00);
        store    = !fetch && MemWrite;
        sel_addr = fetch ? pc : alu_out;
        a        = sel_addr[1:0];
        size     = SZ_WORD;
        sext     = 1'b0;
        if (!fetch) begin
            case (op)
                6'b100000:            begin size = SZ_BYTE; sext = 1'b1; end
                6'b100100, 6'b101000:       size = SZ_BYTE;
                6'b100001:            begin size = SZ_HALF; sext = 1'b1; end
                6'b100101, 6'b101001:       size = SZ_HALF;
                default:                    size = SZ_WORD;
            endcase
        end
        mis = ((size == SZ_WORD) && (a != 2'b00)) || ((size == SZ_HALF) && a[0]);
        case (size)
            SZ_BYTE: begin be = 4'b0001 << a;                  wdata = {4{rt_data[7:0]}};  end
            SZ_HALF: begin be = a[1] ? 4'b1100 : 4'b0011;      wdata = {2{rt_data[15:0]}}; end
            default: begin be = 4'b1111;                       wdata = rt_data;            end
        endcase
        if (!store) be = 4'b1111;
    end

    always_comb begin
        rd_shift = mbus.bus_rdata >> {a_q, 3'b000};
        rd_half  = a_q[1] ? mbus.bus_rdata[31:16] : mbus.bus_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_val = {{24{sext_q & rd_shift[7]}}, rd_shift[7:0]};
            SZ_HALF: load_val = {{16{sext_q & rd_half[15]}}, rd_half};
            default: load_val = mbus.bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = mis ? DONE : REQ;
            REQ: begin
                if (mbus.bus_ack) begin
                    state_d = DONE;
                end else if (cnt == CNT_LAST) begin
                    state_d     = DONE;
                    timeout_hit = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mbus.bus_req   <= 1'b0;
            mbus.bus_we    <= 1'b0;
            mbus.bus_addr  <= '0;
            mbus.bus_be    <= '0;
            mbus.bus_wdata <= '0;
            cnt            <= '0;
            size_q         <= SZ_WORD;
            a_q            <= 2'b00;
            sext_q         <= 1'b0;
            fetch_q        <= 1'b0;
            store_q        <= 1'b0;
            irwrite_q      <= 1'b0;
            ir             <= '0;
            mdr            <= '0;
            misalign       <= 1'b0;
            bus_err        <= 1'b0;
        end else begin
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        size_q    <= size;
                        a_q       <= a;
                        sext_q    <= sext;
                        fetch_q   <= fetch;
                        store_q   <= store;
                        irwrite_q <= IRWrite;
                        if (mis) begin
                            misalign <= 1'b1;
                        end else begin
                            mbus.bus_req   <= 1'b1;
                            mbus.bus_we    <= store;
                            mbus.bus_addr  <= {sel_addr[31:2], 2'b00};
                            mbus.bus_be    <= be;
                            mbus.bus_wdata <= wdata;
                            cnt            <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mbus.bus_ack) begin
                        mbus.bus_req <= 1'b0;
                        mbus.bus_we  <= 1'b0;
                        if (fetch_q && irwrite_q)  ir  <= mbus.bus_rdata;
                        if (!fetch_q && !store_q)  mdr <= load_val;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (timeout_hit) begin
                            mbus.bus_req <= 1'b0;
                            mbus.bus_we  <= 1'b0;
                            bus_err      <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// tb_mem_access: directed and randomized accesses checked against a byte-level reference model.
// Rev 1.0
`default_nettype none

module tb_mem_access;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  IorD = 2'b00;
    logic        MemWrite = 1'b0;
    logic        IRWrite = 1'b0;
    logic [5:0]  op = 6'd0;
    logic [31:0] pc = '0;
    logic [31:0] alu_out = '0;
    logic [31:0] rt_data = '0;
    logic [31:0] ir, mdr;
    logic        busy, done, misalign, bus_err;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_ir = '0;
    logic [31:0] exp_mdr = '0;

    mem_access_if bus_if ();

    mem_access #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .IorD     (IorD),
        .MemWrite (MemWrite),
        .IRWrite  (IRWrite),
        .op       (op),
        .pc       (pc),
        .alu_out  (alu_out),
        .rt_data  (rt_data),
        .mbus     (bus_if.master),
        .ir       (ir),
        .mdr      (mdr),
        .busy     (busy),
        .done     (done),
        .misalign (misalign),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One complete access: drives the bus slave and checks against the model.
    // waits = REQ cycles before ack; a value >= TO never acks.
    task automatic access(input logic [1:0] iord, input logic mw, input logic irw,
                          input logic [5:0] opc, input logic [31:0] addr,
                          input logic [31:0] rt, input int waits, input logic [31:0] word);
        int          n, ai;
        logic        sgn, is_fetch, is_store, mis, fin, timed_out;
        logic [3:0]  ebe;
        logic [31:0] ewd, v;
        logic [7:0]  b [4];

        is_fetch = (iord == 2'b00);
        is_store = !is_fetch && mw;
        n = 4; sgn = 1'b0;
        if (!is_fetch) begin
            case (opc)
                6'h20:        begin n = 1; sgn = 1'b1; end
                6'h24, 6'h28:       n = 1;
                6'h21:        begin n = 2; sgn = 1'b1; end
                6'h25, 6'h29:       n = 2;
                default:            n = 4;
            endcase
        end
        ai  = int'(addr[1:0]);
        mis = (ai % n) != 0;
        for (int i = 0; i < 4; i++) begin
            ebe[i]      = !is_store || (i >= ai && i < ai + n);
            ewd[8*i+:8] = rt[8*(i % n)+:8];
            b[i]        = word[8*i+:8];
        end
        if (n == 1)      v = {{24{sgn & b[ai][7]}}, b[ai]};
        else if (n == 2) v = {{16{sgn & b[ai+1][7]}}, b[ai+1], b[ai]};
        else             v = word;

        @(negedge clk);
        IorD = iord; MemWrite = mw; IRWrite = irw; op = opc; rt_data = rt;
        pc      = is_fetch ? addr : $urandom;
        alu_out = is_fetch ? $urandom : addr;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (mis) begin
            check("mis_done", 32'(done), 32'd1);
            check("mis_flag", 32'(misalign), 32'd1);
            check("mis_noreq", 32'(bus_if.bus_req), 32'd0);
            check("mis_busy", 32'(busy), 32'd1);
            check("mis_ir", ir, exp_ir);
            check("mis_mdr", mdr, exp_mdr);
        end else begin
            check("req", 32'(bus_if.bus_req), 32'd1);
            check("we", 32'(bus_if.bus_we), 32'(is_store));
            check("addr", bus_if.bus_addr, addr & 32'hFFFF_FFFC);
            check("be", 32'(bus_if.bus_be), 32'(ebe));
            if (is_store) check("wdata", bus_if.bus_wdata, ewd);
            check("busy", 32'(busy), 32'd1);
            fin = 1'b0; timed_out = 1'b0;
            for (int k = 0; !fin; k++) begin
                bus_if.bus_ack   = (k == waits);
                bus_if.bus_rdata = (k == waits) ? word : $urandom;
                start = ($urandom & 1) != 0;
                @(posedge clk); #1;
                bus_if.bus_ack = 1'b0;
                if (k == waits)       fin = 1'b1;
                else if (k + 1 == TO) begin fin = 1'b1; timed_out = 1'b1; end
                if (!fin) begin
                    check("wait_req", 32'(bus_if.bus_req), 32'd1);
                    check("wait_done", 32'(done), 32'd0);
                    check("wait_addr", bus_if.bus_addr, addr & 32'hFFFF_FFFC);
                end
            end
            start = 1'b0;
            if (!timed_out) begin
                if (is_fetch && irw)           exp_ir  = word;
                else if (!is_fetch && !is_store) exp_mdr = v;
            end
            check("done", 32'(done), 32'd1);
            check("done_req", 32'(bus_if.bus_req), 32'd0);
            check("done_we", 32'(bus_if.bus_we), 32'd0);
            check("bus_err", 32'(bus_err), 32'(timed_out));
            check("done_misalign", 32'(misalign), 32'd0);
            check("ir", ir, exp_ir);
            check("mdr", mdr, exp_mdr);
        end
        @(posedge clk); #1;
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    logic [5:0] ops [10] = '{6'h23, 6'h2B, 6'h21, 6'h25, 6'h29, 6'h20, 6'h24, 6'h28, 6'h00, 6'h0F};

    initial begin
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(bus_if.bus_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ir", ir, 32'd0);
        check("rst_mdr", mdr, 32'd0);
        rst_n = 1'b1;

        access(2'b00, 1'b0, 1'b1, 6'h00, 32'h0000_0040, 32'd0, 0, 32'h8C08_0004);
        access(2'b01, 1'b0, 1'b0, 6'h20, 32'h0000_0103, 32'd0, 3, 32'h80FF_1234);
        access(2'b01, 1'b0, 1'b0, 6'h24, 32'h0000_0103, 32'd0, 3, 32'h80FF_1234);
        access(2'b10, 1'b1, 1'b0, 6'h29, 32'h0000_0202, 32'h1234_ABCD, 1, 32'd0);
        access(2'b01, 1'b0, 1'b0, 6'h23, 32'h0000_0101, 32'd0, 0, 32'd0);
        access(2'b01, 1'b0, 1'b0, 6'h23, 32'h0000_0200, 32'd0, 100, 32'd0);
        access(2'b01, 1'b0, 1'b0, 6'h23, 32'h0000_0200, 32'd0, 1, 32'hCAFE_F00D);
        access(2'b00, 1'b0, 1'b0, 6'h00, 32'h0000_0044, 32'd0, 2, 32'h1111_2222);
        access(2'b11, 1'b0, 1'b0, 6'h21, 32'h0000_0302, 32'd0, 0, 32'h8001_7FFF);

        // Reset asserted while waiting for ack.
        @(negedge clk);
        IorD = 2'b01; MemWrite = 1'b0; op = 6'h23; alu_out = 32'h0000_0300;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        check("arst_req", 32'(bus_if.bus_req), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_mdr", mdr, 32'd0);
        check("arst_ir", ir, 32'd0);
        exp_ir = '0; exp_mdr = '0;
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b0;
        check("late_ack_busy", 32'(busy), 32'd0);
        check("late_ack_mdr", mdr, 32'd0);
        access(2'b01, 1'b0, 1'b0, 6'h23, 32'h0000_0300, 32'd0, 0, 32'h0BAD_CAFE);

        for (int t = 0; t < 60; t++) begin
            int w;
            w = (($urandom & 7) == 0) ? 50 : int'($urandom_range(0, 5));
            access(2'($urandom), 1'($urandom), 1'($urandom), ops[$urandom_range(0, 9)],
                   $urandom, $urandom, w, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

`default_nettype wire
